stream_match_ctrl: RTL and testbench
====================================

Name: stream_match_ctrl

Overview:
- Sequencing controller for the serial key-capture and compare path.
- Accepts a qualified serial bit stream and assembles exactly 128 bits, MSB first, into a capture register.
- On end_of_sequence, checks the received length, then compares the captured word against up to four prestored constant keys, one key per cycle.
- Returns a match/no-match/length-error verdict over a valid/ready handshake; sits between the serial front end and downstream crypto/authentication logic.

Parameters:
- WIDTH, 128, captured word width in bits; fixed at 128 for this revision.
- NUM_KEYS, 4, number of prestored keys compared; legal range 1..4.
- KEY0, 128'h0123456789ABCDEF_FEDCBA9876543210, prestored key 0.
- KEY1, 128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678, prestored key 1.
- KEY2, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000, prestored key 2.
- KEY3, 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A, prestored key 3.

Ports:
- clk  in  1  single clock; all logic updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_in  in  1  serial data bit, MSB of the word first.
- end_of_sequence  in  1  one-cycle pulse marking the end of the stream.
- abort  in  1  synchronous cancel of the current operation.
- result_ready  in  1  consumer accepts the result.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  verdict is valid.
- match  out  1  captured word equals a key.
- match_idx  out  2  index of the lowest matching key.
- len_error  out  1  received bit count was not 128.
- captured  out  128  assembled word.

Behaviour:
- Reset: on rst high at a clock edge, all outputs, the bit counter (8 bits), the overflow flag and the compare index become 0, and the state becomes IDLE. rst has highest priority, then abort, then everything else.
- Bit capture: each accepted bit performs captured <= {captured[126:0], bit_in} and increments the counter.
- Overflow: once 128 bits are held, further bit_valid beats are dropped and set the overflow flag.
- Counter: never wraps.
- States: IDLE, SHIFT, COMPARE, DONE.

State transitions:
- IDLE:
  - bit_valid: capture the bit with count=1, clear captured's prior content first, go to SHIFT.
  - end_of_sequence without bit_valid: go to DONE with len_error=1.
- SHIFT:
  - capture bits as above.
  - end_of_sequence: a bit_valid in the same cycle is captured first, then the length is evaluated using the updated count.
  - count==128 and no overflow: go to COMPARE with idx=0.
  - otherwise: go to DONE with len_error=1, match=0.
- COMPARE: each cycle, compare captured with KEY[idx].
  - equal: go to DONE with match=1, match_idx=idx.
  - not equal and idx==NUM_KEYS-1: go to DONE with match=0, match_idx=0.
  - otherwise: idx+1.
  - bit_valid and end_of_sequence are ignored.
- DONE:
  - result_valid=1; match, match_idx, len_error and captured are held stable.
  - result_valid && result_ready: go to IDLE next edge; result_valid, match and len_error clear; count and overflow clear; captured holds.
  - Inputs other than result_ready and abort are ignored.

Latency (end_of_sequence sampled at edge E0):
- Match on key k: result_valid high after edge E0+k+1.
- No match: result_valid high after edge E0+NUM_KEYS.
- Length error: result_valid high after edge E0.

Abort:
- In any state, abort goes to IDLE next edge.
- Clears result_valid, match, len_error, count and overflow; captured holds.
- An in-flight result is discarded.

Other rules:
- No partial results; no back-to-back stream acceptance while busy.
- Keys with index >= NUM_KEYS are never compared.

Test Plan:
- Shift in KEY0 (128 bits, bit_valid every cycle), EOS with the last bit, result_ready=1 -> result_valid after E0+1; match=1, match_idx=0, len_error=0, captured=KEY0.
- Shift in KEY3 with bit_valid gaps, EOS one cycle after the last bit, result_ready held 0 for 5 cycles -> result_valid at E0+4, outputs held stable until ready, match_idx=3, then busy drops.
- Shift in 128'h0 -> no match; result_valid after E0+4; match=0, len_error=0.
- Length errors: 127 bits + EOS -> len_error=1 after E0. 130 bits + EOS -> len_error=1, captured equals the first 128 bits.
- abort asserted mid-SHIFT (bit 60) and in COMPARE (idx=1) -> busy=0 the next cycle, no result_valid. A following clean KEY1 stream -> match_idx=1.
- rst asserted in DONE with result_valid=1 -> all outputs 0 the next cycle. EOS in IDLE with no bits -> len_error=1.

Source files
------------

// File: rtl/stream_match_if.sv
// Handshake and data bundle between the serial front end, the match controller and its consumer.
interface stream_match_if #(
    parameter int unsigned WIDTH = 128
);
    logic             bit_valid;
    logic             bit_in;
    logic             end_of_sequence;
    logic             abort;
    logic             result_ready;
    logic             busy;
    logic             result_valid;
    logic             match;
    logic [1:0]       match_idx;
    logic             len_error;
    logic [WIDTH-1:0] captured;

    modport master (
        output bit_valid, bit_in, end_of_sequence, abort, result_ready,
        input  busy, result_valid, match, match_idx, len_error, captured
    );

    modport slave (
        input  bit_valid, bit_in, end_of_sequence, abort, result_ready,
        output busy, result_valid, match, match_idx, len_error, captured
    );
endinterface

// File: rtl/stream_match_ctrl.sv
// Serial key capture: shifts in a 128-bit word MSB first, checks its length, then compares it
// against up to four constant keys one per cycle and hands back a verdict over valid/ready.
module stream_match_ctrl #(
    parameter int unsigned  WIDTH    = 128,
    parameter int unsigned  NUM_KEYS = 4,
    parameter logic [127:0] KEY0     = 128'h0123456789ABCDEF_FEDCBA9876543210,
    parameter logic [127:0] KEY1     = 128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678,
    parameter logic [127:0] KEY2     = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000,
    parameter logic [127:0] KEY3     = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A
) (
    input  logic          clk,
    input  logic          rst,
    stream_match_if.slave sm
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StShift   = 2'd1;
    localparam logic [1:0] StCompare = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    localparam logic [7:0] FullCnt = 8'(WIDTH);
    localparam logic [1:0] LastIdx = 2'(NUM_KEYS - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       idx_q, idx_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             match_q, match_d;
    logic [1:0]       match_idx_q, match_idx_d;
    logic             len_err_q, len_err_d;
    logic             rvalid_q, rvalid_d;

    function automatic logic [WIDTH-1:0] key_at(input logic [1:0] idx);
        case (idx)
            2'd0:    key_at = KEY0[WIDTH-1:0];
            2'd1:    key_at = KEY1[WIDTH-1:0];
            2'd2:    key_at = KEY2[WIDTH-1:0];
            default: key_at = KEY3[WIDTH-1:0];
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        idx_d       = idx_q;
        cap_d       = cap_q;
        match_d     = match_q;
        match_idx_d = match_idx_q;
        len_err_d   = len_err_q;
        rvalid_d    = rvalid_q;

        case (state_q)
            StIdle: begin
                if (sm.bit_valid) begin
                    cap_d   = {{(WIDTH-1){1'b0}}, sm.bit_in};
                    cnt_d   = 8'd1;
                    ovf_d   = 1'b0;
                    state_d = StShift;
                end
                // EOS alone, or EOS with a single bit, can only be a short stream.
                if (sm.end_of_sequence) begin
                    state_d     = StDone;
                    len_err_d   = 1'b1;
                    match_d     = 1'b0;
                    match_idx_d = 2'd0;
                    rvalid_d    = 1'b1;
                end
            end
            StShift: begin
                if (sm.bit_valid) begin
                    if (cnt_q < FullCnt) begin
                        cap_d = {cap_q[WIDTH-2:0], sm.bit_in};
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                // Length is judged on the count after this cycle's bit has been taken.
                if (sm.end_of_sequence) begin
                    if (cnt_d == FullCnt && !ovf_d) begin
                        state_d = StCompare;
                        idx_d   = 2'd0;
                    end else begin
                        state_d     = StDone;
                        len_err_d   = 1'b1;
                        match_d     = 1'b0;
                        match_idx_d = 2'd0;
                        rvalid_d    = 1'b1;
                    end
                end
            end
            StCompare: begin
                if (cap_q == key_at(idx_q)) begin
                    state_d     = StDone;
                    match_d     = 1'b1;
                    match_idx_d = idx_q;
                    len_err_d   = 1'b0;
                    rvalid_d    = 1'b1;
                end else if (idx_q == LastIdx) begin
                    state_d     = StDone;
                    match_d     = 1'b0;
                    match_idx_d = 2'd0;
                    len_err_d   = 1'b0;
                    rvalid_d    = 1'b1;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            StDone: begin
                if (sm.result_ready) begin
                    state_d   = StIdle;
                    rvalid_d  = 1'b0;
                    match_d   = 1'b0;
                    len_err_d = 1'b0;
                    cnt_d     = 8'd0;
                    ovf_d     = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort discards everything in flight but leaves the captured word visible.
        if (sm.abort) begin
            state_d   = StIdle;
            cap_d     = cap_q;
            rvalid_d  = 1'b0;
            match_d   = 1'b0;
            len_err_d = 1'b0;
            cnt_d     = 8'd0;
            ovf_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            ovf_q       <= 1'b0;
            idx_q       <= 2'd0;
            cap_q       <= '0;
            match_q     <= 1'b0;
            match_idx_q <= 2'd0;
            len_err_q   <= 1'b0;
            rvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            idx_q       <= idx_d;
            cap_q       <= cap_d;
            match_q     <= match_d;
            match_idx_q <= match_idx_d;
            len_err_q   <= len_err_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign sm.busy         = (state_q != StIdle);
    assign sm.result_valid = rvalid_q;
    assign sm.match        = match_q;
    assign sm.match_idx    = match_idx_q;
    assign sm.len_error    = len_err_q;
    assign sm.captured     = cap_q;

endmodule

// File: tb/tb_stream_match_ctrl.sv
// Bench for stream_match_ctrl: fixed vectors, hand-built abort/reset sequences and random
// streams judged by a stream-level reference model.
module tb_stream_match_ctrl;

    localparam int unsigned NUM_KEYS = 4;
    localparam logic [127:0] K0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] K1 = 128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678;
    localparam logic [127:0] K2 = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
    localparam logic [127:0] K3 = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_match_if #(.WIDTH(128)) sm ();

    stream_match_ctrl #(
        .WIDTH    (128),
        .NUM_KEYS (NUM_KEYS),
        .KEY0     (K0),
        .KEY1     (K1),
        .KEY2     (K2),
        .KEY3     (K3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sm  (sm)
    );

    typedef struct {
        logic [127:0] word;
        int           nbits;
        bit           gaps;
        bit           eos_last;
        int           hold;
        logic [127:0] exp_cap;
        bit           exp_m;
        logic [1:0]   exp_mi;
        bit           exp_le;
        int           exp_lat;
    } vec_t;

    logic [127:0] keys [4];
    vec_t         vecs [7];
    bit           stim [$];
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic load_word(input logic [127:0] w, input int nbits);
        stim.delete();
        for (int i = 0; i < nbits; i++) begin
            if (i < 128) stim.push_back(w[127-i]);
            else         stim.push_back(i[0]);
        end
    endtask

    // Reference: pack the first 128 bits, judge length, then find the lowest equal key.
    task automatic model(output logic [127:0] cap, output bit m, output logic [1:0] mi,
                         output bit le, output int lat);
        cap = '0;
        for (int i = 0; i < stim.size() && i < 128; i++) cap = {cap[126:0], stim[i]};
        le  = (stim.size() != 128);
        m   = 1'b0;
        mi  = 2'd0;
        lat = 0;
        if (!le) begin
            lat = NUM_KEYS;
            for (int k = NUM_KEYS - 1; k >= 0; k--) begin
                if (cap == keys[k]) begin
                    m   = 1'b1;
                    mi  = k[1:0];
                    lat = k + 1;
                end
            end
        end
    endtask

    task automatic send(input bit gaps, input bit eos_last, input bit do_eos);
        for (int i = 0; i < stim.size(); i++) begin
            sm.bit_valid       = 1'b1;
            sm.bit_in          = stim[i];
            sm.end_of_sequence = do_eos && eos_last && (i == stim.size() - 1);
            tick();
            sm.bit_valid       = 1'b0;
            sm.end_of_sequence = 1'b0;
            if (gaps && i < stim.size() - 1 && $urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 3)) tick();
        end
        if (do_eos && (!eos_last || stim.size() == 0)) begin
            sm.end_of_sequence = 1'b1;
            tick();
            sm.end_of_sequence = 1'b0;
        end
    endtask

    task automatic run_txn(input string tag, input bit gaps, input bit eos_last, input int hold,
                           input logic [127:0] cap, input bit m, input logic [1:0] mi,
                           input bit le, input int lat);
        int cyc;
        send(gaps, eos_last, 1'b1);
        cyc = 0;
        while (sm.result_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, " latency"}, cyc, lat);
        chk({tag, " verdict"}, {sm.busy, sm.match, sm.match_idx, sm.len_error}, {1'b1, m, mi, le});
        chk({tag, " captured"}, sm.captured, cap);
        repeat (hold) begin
            tick();
            chk({tag, " hold"}, {sm.result_valid, sm.match, sm.match_idx, sm.len_error, sm.captured},
                {1'b1, m, mi, le, cap});
        end
        sm.result_ready = 1'b1;
        tick();
        sm.result_ready = 1'b0;
        chk({tag, " release"}, {sm.busy, sm.result_valid, sm.match, sm.len_error, sm.captured},
            {4'b0000, cap});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] e_cap;
        bit           e_m;
        logic [1:0]   e_mi;
        bit           e_le;
        int           e_lat;
        bit           seen;

        keys[0] = K0; keys[1] = K1; keys[2] = K2; keys[3] = K3;
        vecs[0] = '{K0, 128, 1'b0, 1'b1, 0, K0,      1'b1, 2'd0, 1'b0, 1};
        vecs[1] = '{K3, 128, 1'b1, 1'b0, 5, K3,      1'b1, 2'd3, 1'b0, 4};
        vecs[2] = '{'0, 128, 1'b0, 1'b1, 2, '0,      1'b0, 2'd0, 1'b0, 4};
        vecs[3] = '{K0, 127, 1'b0, 1'b1, 0, K0 >> 1, 1'b0, 2'd0, 1'b1, 0};
        vecs[4] = '{K1, 130, 1'b0, 1'b1, 0, K1,      1'b0, 2'd0, 1'b1, 0};
        vecs[5] = '{K2, 128, 1'b1, 1'b1, 1, K2,      1'b1, 2'd2, 1'b0, 3};
        vecs[6] = '{K1, 128, 1'b0, 1'b0, 0, K1,      1'b1, 2'd1, 1'b0, 2};

        rst = 1'b1;
        sm.bit_valid = 1'b0; sm.bit_in = 1'b0; sm.end_of_sequence = 1'b0;
        sm.abort = 1'b0; sm.result_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset", {sm.busy, sm.result_valid, sm.match, sm.match_idx, sm.len_error, sm.captured},
            '0);

        for (int i = 0; i < 7; i++) begin
            load_word(vecs[i].word, vecs[i].nbits);
            run_txn($sformatf("vec%0d", i), vecs[i].gaps, vecs[i].eos_last, vecs[i].hold,
                    vecs[i].exp_cap, vecs[i].exp_m, vecs[i].exp_mi, vecs[i].exp_le,
                    vecs[i].exp_lat);
        end

        // Abort in the middle of shifting.
        load_word(K0, 60);
        send(1'b0, 1'b0, 1'b0);
        sm.abort = 1'b1;
        tick();
        sm.abort = 1'b0;
        chk("abort_shift busy", sm.busy, 1'b0);
        seen = 1'b0;
        repeat (6) begin tick(); seen |= sm.result_valid; end
        chk("abort_shift no_result", seen, 1'b0);

        // Abort while comparing against key 1 (stream would otherwise match key 2).
        load_word(K2, 128);
        send(1'b0, 1'b1, 1'b1);
        tick();
        sm.abort = 1'b1;
        tick();
        sm.abort = 1'b0;
        chk("abort_cmp busy", sm.busy, 1'b0);
        seen = 1'b0;
        repeat (6) begin tick(); seen |= sm.result_valid; end
        chk("abort_cmp no_result", seen, 1'b0);

        load_word(K1, 128);
        run_txn("after_abort", 1'b0, 1'b1, 0, K1, 1'b1, 2'd1, 1'b0, 2);

        // Reset while a length-error verdict is pending.
        load_word(K3, 127);
        send(1'b0, 1'b1, 1'b1);
        chk("pre_rst valid", sm.result_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_in_done", {sm.busy, sm.result_valid, sm.match, sm.match_idx, sm.len_error,
            sm.captured}, '0);

        // EOS with no bits at all.
        stim.delete();
        run_txn("eos_only", 1'b0, 1'b1, 1, '0, 1'b0, 2'd0, 1'b1, 0);

        for (int t = 0; t < 30; t++) begin
            int r;
            int nb;
            logic [127:0] w;
            r  = $urandom_range(0, 5);
            if (r < 4) w = keys[r];
            else       w = {$urandom, $urandom, $urandom, $urandom};
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(120, 133) : 128;
            load_word(w, nb);
            model(e_cap, e_m, e_mi, e_le, e_lat);
            run_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), e_cap, e_m, e_mi, e_le, e_lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
